// File: rtl/keccak_pkg.sv
// Shared types and constants for the Keccak permutation control logic.
//   keccak_cu_state_e : control-unit FSM states
//   KECCAK_NROUNDS    : rounds in a full Keccak-f[1600] permutation
package keccak_pkg;

  localparam int unsigned KECCAK_NROUNDS = 24;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StPermute,
    StDone
  } keccak_cu_state_e;

endpackage

// File: rtl/keccak_round_cnt.sv
// Saturating round counter for the Keccak control unit.
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset
//   clr_i   : return count to 0 (wins over en_i)
//   en_i    : advance one round; holds once the last round is reached
//   cnt_o   : current round index
//   last_o  : cnt_o == NumRounds-1
module keccak_round_cnt #(
  parameter int unsigned NumRounds = 24,
  localparam int unsigned CntW = $clog2(NumRounds)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            en_i,
  output logic [CntW-1:0] cnt_o,
  output logic            last_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign last_o = (cnt_q == CntW'(NumRounds - 1));
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !last_o) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/keccak_cu_multi.sv
// Control unit for the Keccak permutation datapath. Sequences multi-block absorbs: each block is
// a load handshake followed by NUM_ROUNDS single-cycle rounds.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   start_i           : start request (IDLE only); nblocks_i sampled then, 0 means 1
//   abort_i           : cancel any in-flight operation
//   blk_valid_i       : upstream block available; blk_ready_o: CU in LOAD
//   load_dp_o         : datapath XORs block into state (combinational handshake)
//   round_en_o        : datapath executes a round; round_idx_o: its index (0 outside PERMUTE)
//   busy_o, done_o    : not idle / one-cycle completion pulse
//   status_o          : sticky done flag, cleared by intr_clr_i or a new start
//   intr_en_i, intr_clr_i, intr_o : maskable sticky interrupt
// Build option: KECCAK_CU_INTR_EN enables the interrupt flop; otherwise intr_o is tied 0 and
// intr_en_i is ignored (intr_clr_i still clears status_o).
module keccak_cu_multi
  import keccak_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = KECCAK_NROUNDS,
  parameter int unsigned BLK_W = 8,
  localparam int unsigned RND_W = $clog2(NUM_ROUNDS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [BLK_W-1:0] nblocks_i,
  input  logic             abort_i,
  input  logic             blk_valid_i,
  output logic             blk_ready_o,
  output logic             load_dp_o,
  output logic             round_en_o,
  output logic [RND_W-1:0] round_idx_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             status_o,
  input  logic             intr_en_i,
  input  logic             intr_clr_i,
  output logic             intr_o
);

  keccak_cu_state_e state_q, state_d;
  logic [BLK_W-1:0] nblocks_q, nblocks_d;
  logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
  logic             status_q, status_d;

  logic             start_acc;
  logic             done_set;
  logic             last_blk;
  logic             rnd_clr;
  logic             rnd_en;
  logic             rnd_last;
  logic [RND_W-1:0] rnd_cnt;

  assign last_blk  = (blk_cnt_q == nblocks_q - BLK_W'(1));
  assign start_acc = (state_q == StIdle) && start_i;
  // Abort in DONE still leaves status/interrupt untouched.
  assign done_set  = (state_q == StDone) && !abort_i;

  assign rnd_en  = (state_q == StPermute);
  assign rnd_clr = load_dp_o || (busy_o && abort_i);

  keccak_round_cnt #(
    .NumRounds(NUM_ROUNDS)
  ) u_round_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (rnd_clr),
    .en_i  (rnd_en),
    .cnt_o (rnd_cnt),
    .last_o(rnd_last)
  );

  always_comb begin
    state_d   = state_q;
    nblocks_d = nblocks_q;
    blk_cnt_d = blk_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d   = StLoad;
          nblocks_d = (nblocks_i == '0) ? BLK_W'(1) : nblocks_i;
          blk_cnt_d = '0;
        end
      end
      StLoad: begin
        if (blk_valid_i) begin
          state_d = StPermute;
        end
      end
      StPermute: begin
        if (rnd_last) begin
          if (last_blk) begin
            state_d = StDone;
          end else begin
            state_d   = StLoad;
            blk_cnt_d = blk_cnt_q + BLK_W'(1);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (abort_i && (state_q != StIdle)) begin
      state_d   = StIdle;
      blk_cnt_d = blk_cnt_q;
    end
  end

  // Completion set wins over a coincident clear; start always begins with a clean flag.
  always_comb begin
    status_d = status_q;
    if (start_acc) begin
      status_d = 1'b0;
    end else if (done_set) begin
      status_d = 1'b1;
    end else if (intr_clr_i) begin
      status_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      nblocks_q <= '0;
      blk_cnt_q <= '0;
      status_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      nblocks_q <= nblocks_d;
      blk_cnt_q <= blk_cnt_d;
      status_q  <= status_d;
    end
  end

`ifdef KECCAK_CU_INTR_EN
  logic intr_q, intr_d;

  always_comb begin
    intr_d = intr_q;
    if (start_acc) begin
      intr_d = 1'b0;
    end else if (done_set && intr_en_i) begin
      intr_d = 1'b1;
    end else if (intr_clr_i) begin
      intr_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      intr_q <= 1'b0;
    end else begin
      intr_q <= intr_d;
    end
  end

  assign intr_o = intr_q;
`else
  logic unused_intr_en;
  assign unused_intr_en = intr_en_i;
  assign intr_o         = 1'b0;
`endif

  assign blk_ready_o = (state_q == StLoad);
  assign load_dp_o   = blk_valid_i && blk_ready_o;
  assign round_en_o  = (state_q == StPermute);
  assign round_idx_o = round_en_o ? rnd_cnt : '0;
  assign busy_o      = (state_q != StIdle);
  assign done_o      = (state_q == StDone);
  assign status_o    = status_q;

endmodule

// File: tb/tb_keccak_cu_multi.sv
module tb_keccak_cu_multi;

  localparam int unsigned NR = 24;
  localparam int unsigned BW = 8;
  localparam int unsigned RW = 5;
`ifdef KECCAK_CU_INTR_EN
  localparam bit IntrOn = 1'b1;
`else
  localparam bit IntrOn = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic [BW-1:0] nblocks_i = '0;
  logic          abort_i = 1'b0;
  logic          blk_valid_i = 1'b0;
  logic          blk_ready_o;
  logic          load_dp_o;
  logic          round_en_o;
  logic [RW-1:0] round_idx_o;
  logic          busy_o;
  logic          done_o;
  logic          status_o;
  logic          intr_en_i = 1'b0;
  logic          intr_clr_i = 1'b0;
  logic          intr_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  keccak_cu_multi #(
    .NUM_ROUNDS(NR),
    .BLK_W     (BW)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .nblocks_i  (nblocks_i),
    .abort_i    (abort_i),
    .blk_valid_i(blk_valid_i),
    .blk_ready_o(blk_ready_o),
    .load_dp_o  (load_dp_o),
    .round_en_o (round_en_o),
    .round_idx_o(round_idx_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .status_o   (status_o),
    .intr_en_i  (intr_en_i),
    .intr_clr_i (intr_clr_i),
    .intr_o     (intr_o)
  );

  typedef struct {
    int nb;
    int gap;
    bit ien;
    int e_loads;
    int e_rounds;
    int e_dones;
    int e_cycles;
    bit e_status;
    bit e_intr;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge, outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst_i = 1'b1;
    start_i = 1'b0;
    abort_i = 1'b0;
    intr_clr_i = 1'b0;
    blk_valid_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  function automatic int all_outs();
    return int'({blk_ready_o, load_dp_o, round_en_o, round_idx_o, busy_o, done_o, status_o,
                 intr_o});
  endfunction

  // Cycle 0 is the start cycle; upstream stalls 'gap' LOAD cycles before every block but the first.
  task automatic run_op(input int nb, input int gap, input bit ien, output int loads,
                        output int rounds, output int dones, output int cycles,
                        output int st0, output int st, output int it);
    int gap_cnt = 0;
    bit seen = 1'b0;
    loads = 0;
    rounds = 0;
    dones = 0;
    cycles = -1;
    st0 = -1;
    tick();
    nblocks_i = BW'(nb);
    start_i = 1'b1;
    blk_valid_i = 1'b1;
    intr_en_i = ien;
    settle();
    for (int c = 1; c < 2000 && !seen; c++) begin
      tick();
      start_i = 1'b0;
      blk_valid_i = (gap_cnt == 0);
      settle();
      if (c == 1) st0 = int'(status_o);
      if (load_dp_o) begin
        loads++;
        gap_cnt = gap;
      end else if (blk_ready_o && gap_cnt > 0) begin
        gap_cnt--;
      end
      rounds += int'(round_en_o);
      dones += int'(done_o);
      if (done_o) begin
        seen = 1'b1;
        cycles = c;
      end
    end
    tick();
    settle();
    st = int'(status_o);
    it = int'(intr_o);
  endtask

  initial begin
    vec_t vecs[5];
    int loads, rounds, dones, cycles, st0, st, it;
    int bad_en, bad_idx, bad_load, bad_done, bad_busy;
    bit exp_en;

    vecs[0] = '{1, 0, 1'b0, 1, 24, 1, 26, 1'b1, 1'b0};
    vecs[1] = '{3, 5, 1'b1, 3, 72, 1, 86, 1'b1, IntrOn};
    vecs[2] = '{0, 0, 1'b0, 1, 24, 1, 26, 1'b1, 1'b0};
    vecs[3] = '{2, 0, 1'b1, 2, 48, 1, 51, 1'b1, IntrOn};
    vecs[4] = '{4, 2, 1'b1, 4, 96, 1, 107, 1'b1, IntrOn};

    // Reset state
    tick();
    tick();
    rst_i = 1'b0;
    settle();
    chk("reset_outputs", all_outs(), 0);

    // Table-driven complete operations
    for (int v = 0; v < 5; v++) begin
      run_op(vecs[v].nb, vecs[v].gap, vecs[v].ien, loads, rounds, dones, cycles, st0, st, it);
      chk($sformatf("v%0d_loads", v), loads, vecs[v].e_loads);
      chk($sformatf("v%0d_rounds", v), rounds, vecs[v].e_rounds);
      chk($sformatf("v%0d_dones", v), dones, vecs[v].e_dones);
      chk($sformatf("v%0d_done_cycle", v), cycles, vecs[v].e_cycles);
      chk($sformatf("v%0d_status_cleared_on_start", v), st0, 0);
      chk($sformatf("v%0d_status", v), st, int'(vecs[v].e_status));
      chk($sformatf("v%0d_intr", v), it, int'(vecs[v].e_intr));
      chk($sformatf("v%0d_idle_after", v), int'(busy_o), 0);
    end

    // Interrupt/status clear pulse, then abort+start together in IDLE (start wins)
    intr_clr_i = 1'b1;
    tick();
    intr_clr_i = 1'b0;
    settle();
    chk("clr_status", int'(status_o), 0);
    chk("clr_intr", int'(intr_o), 0);
    blk_valid_i = 1'b0;
    start_i = 1'b1;
    abort_i = 1'b1;
    nblocks_i = BW'(1);
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    settle();
    chk("start_beats_abort_in_idle", int'(blk_ready_o), 1);

    // Reset asserted while at round 10
    do_reset();
    tick();
    nblocks_i = BW'(1);
    start_i = 1'b1;
    blk_valid_i = 1'b1;
    settle();
    for (int c = 1; c <= 12; c++) begin
      tick();
      start_i = 1'b0;
      settle();
    end
    chk("pre_reset_round_idx", int'(round_idx_o), 10);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    settle();
    chk("mid_op_reset_outputs", all_outs(), 0);

    // Exact single-block timeline, clear coincident with DONE, restart in first IDLE cycle
    do_reset();
    bad_en = 0;
    bad_idx = 0;
    bad_load = 0;
    bad_done = 0;
    bad_busy = 0;
    tick();
    nblocks_i = BW'(1);
    start_i = 1'b1;
    blk_valid_i = 1'b1;
    intr_en_i = 1'b1;
    settle();
    for (int c = 1; c <= 27; c++) begin
      tick();
      start_i = 1'b0;
      intr_clr_i = (c == 26);
      settle();
      exp_en = (c >= 2) && (c <= 25);
      if (round_en_o != exp_en) bad_en++;
      if (int'(round_idx_o) != (exp_en ? c - 2 : 0)) bad_idx++;
      if (load_dp_o != (c == 1)) bad_load++;
      if (done_o != (c == 26)) bad_done++;
      if (busy_o != (c <= 26)) bad_busy++;
    end
    chk("t1_round_en_cycles", bad_en, 0);
    chk("t1_round_idx_seq", bad_idx, 0);
    chk("t1_load_dp_cycles", bad_load, 0);
    chk("t1_done_cycle", bad_done, 0);
    chk("t1_busy_cycles", bad_busy, 0);
    chk("t1_status_set_wins", int'(status_o), 1);
    chk("t1_intr_set_wins", int'(intr_o), int'(IntrOn));
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    settle();
    chk("restart_first_idle", int'(blk_ready_o), 1);
    chk("restart_clears_status", int'(status_o), 0);

    // Abort at round 5 of block 2, with a start pulse during busy that must be ignored
    do_reset();
    rounds = 0;
    dones = 0;
    tick();
    nblocks_i = BW'(3);
    start_i = 1'b1;
    blk_valid_i = 1'b1;
    settle();
    for (int c = 1; c <= 32; c++) begin
      tick();
      start_i = (c == 10);
      settle();
      rounds += int'(round_en_o);
      dones += int'(done_o);
    end
    start_i = 1'b0;
    chk("abort_at_round5", int'(round_idx_o), 5);
    chk("rounds_before_abort", rounds, 30);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    settle();
    chk("abort_busy", int'(busy_o), 0);
    chk("abort_round_en", int'(round_en_o), 0);
    chk("abort_round_idx", int'(round_idx_o), 0);
    bad_busy = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      settle();
      dones += int'(done_o);
      bad_busy += int'(busy_o);
    end
    chk("abort_no_done", dones, 0);
    chk("abort_stays_idle", bad_busy, 0);
    chk("abort_status", int'(status_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keccak_cu_multi.md
# keccak_cu_multi

Parametrised control unit for the Keccak permutation datapath: sequences multi-block absorb operations, each block being a load handshake followed by NUM_ROUNDS single-cycle rounds. Drives round index and round enable to the round-constant/datapath logic. Supports abort, a sticky status flag and a maskable, clearable interrupt. Sits between the bus-side register/loader logic and the permutation datapath.

## Interface
- NUM_ROUNDS, 24, rounds per permutation (≥2)
- BLK_W, 8, width of block-count input
- RND_W, $clog2(NUM_ROUNDS), round-index width (derived, not overridden)
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset: synchronous, active-high
- start_i  in  1  start request, honoured only in IDLE
- nblocks_i  in  BLK_W  blocks to absorb, sampled on accepted start; 0 treated as 1
- abort_i  in  1  cancel operation
- blk_valid_i  in  1  upstream block available
- blk_ready_o  out  1  CU accepts a block (LOAD state)
- load_dp_o  out  1  datapath XORs block into state (= blk_valid_i & blk_ready_o)
- round_en_o  out  1  datapath executes one round this cycle
- round_idx_o  out  RND_W  current round index 0..NUM_ROUNDS-1
- busy_o  out  1  state ≠ IDLE
- done_o  out  1  one-cycle completion pulse
- status_o  out  1  sticky done flag
- intr_en_i  in  1  interrupt enable
- intr_clr_i  in  1  clears status_o and intr_o
- intr_o  out  1  sticky interrupt, level

## Operation
- States: IDLE, LOAD, PERMUTE, DONE.
- IDLE: start_i → LOAD; latch nblocks (0→1), blk_cnt←0, clear status_o/intr_o.
- LOAD: blk_ready_o=1; on blk_valid_i: load_dp_o=1 same cycle, round_cnt←0, → PERMUTE. Otherwise wait indefinitely.
- PERMUTE: round_en_o=1, round_idx_o=round_cnt; round_cnt increments each cycle. At round_cnt==NUM_ROUNDS-1: if blk_cnt==nblocks-1 → DONE, else blk_cnt++ and → LOAD.
- DONE: done_o=1; status_o←1; intr_o←1 if intr_en_i; → IDLE.
- abort_i in any non-IDLE state: → IDLE next cycle, overrides every other transition; no done_o, status_o/intr_o unchanged. abort_i in IDLE ignored; abort_i with start_i in IDLE: start wins.
- start_i outside IDLE ignored (no queueing).
- intr_clr_i and set in the same cycle: set wins. intr_clr_i clears both status_o and intr_o.
- round_idx_o = 0 outside PERMUTE.
- Counters never wrap: round_cnt bounded by NUM_ROUNDS-1, blk_cnt by latched nblocks-1.

## Timing
- Reset: state IDLE, all counters 0, every output 0 (blk_ready_o, load_dp_o, round_en_o, round_idx_o, busy_o, done_o, status_o, intr_o).
- Reset asserted mid-operation: next cycle identical to post-reset state; in-flight operation lost.
- State outputs Moore-decoded from registered state; load_dp_o is the only combinational (Mealy) output.
- Single block, blk_valid_i held high: start in cycle 0 → LOAD cycle 1 (load_dp_o) → PERMUTE cycles 2..NUM_ROUNDS+1 → DONE cycle NUM_ROUNDS+2 (done_o) → IDLE; status_o/intr_o visible from cycle NUM_ROUNDS+3.
- Each additional block costs 1 + NUM_ROUNDS cycles with no upstream stall.
- New start accepted in the first IDLE cycle after DONE.

## Configuration
- KECCAK_CU_INTR_EN defined: intr_o, intr_en_i, intr_clr_i behave as above.
- Undefined: intr_o tied 0, intr_en_i ignored; intr_clr_i still clears status_o; no interrupt flop synthesised.

## Structure
- keccak_pkg: keccak_cu_state_e enum (IDLE, LOAD, PERMUTE, DONE), constant KECCAK_NROUNDS = 24 used as NUM_ROUNDS default.
- One sub-module: keccak_round_cnt — parametrised round counter with clear, enable and last-round flag; instantiated for round_cnt. blk_cnt stays inline.

## Test plan
- Reset mid-PERMUTE (round 10) → next cycle all outputs 0, busy_o=0, round_idx_o=0.
- nblocks_i=1, blk_valid_i=1, start at cycle 0 → round_en_o cycles 2–25, round_idx_o 0..23, done_o only at cycle 26, status_o=1 from 27.
- nblocks_i=3, blk_valid_i low 5 cycles before 2nd block → exactly 3 load_dp_o pulses, 72 round_en_o cycles, single done_o.
- nblocks_i=0 → behaves as 1 block: one load_dp_o, 24 rounds, one done_o.
- abort_i at round 5 of block 2 → IDLE next cycle, no done_o, status_o unchanged; start_i during busy ignored.
- intr_en_i=1 completion → intr_o=1; intr_clr_i pulse → intr_o=status_o=0; clear coincident with DONE → intr_o=1; macro undefined → intr_o stays 0.
